seven_seg_multi_ctrl: RTL and testbench
=======================================

// Module: seven_seg_multi_ctrl
// PURPOSE
//  Avalon-MM slave driving NUM_DIGITS static seven-segment displays; successor to the single-digit PIO.
//  Each digit is either raw segment data or a 4-bit hex value decoded in hardware.
//  Per-digit blinking runs from a programmable clock divider.
//  Sits on the system interconnect beside the other PIO slaves; seg_out goes straight to board pins.
// PARAMETERS
//  NUM_DIGITS   6   number of digits, 1..12
//  ADDR_W       4   word-address width; must satisfy 4+NUM_DIGITS <= 2**ADDR_W
//  ACTIVE_LOW   1   1: segment lit when pin=0 (board default); 0: lit when pin=1
//  DIV_W        32  width of blink divider register/counter
// PORTS
//  clk         in   1              system clock; all logic on rising edge
//  reset_n     in   1              asynchronous assert, active-low reset
//  address     in   ADDR_W         word address
//  chipselect  in   1              slave select
//  write_n     in   1              active-low write strobe
//  writedata   in   32             write data
//  readdata    out  32             read data, combinational from address (0 wait states)
//  seg_out     out  7*NUM_DIGITS   digit k on [7k+6:7k]; bit0=seg a .. bit6=seg g
// BEHAVIOUR
//  Register map (word addresses); write = chipselect & ~write_n:
//   0 CTRL      [0] enable: 0 blanks all digits. Other bits read 0.
//   1 DECODE    [N-1:0] 1 = digit k hex-decodes DIGIT_k[3:0]; 0 = DIGIT_k[6:0] is raw segments
//   2 BLINK     [N-1:0] 1 = digit k blinks
//   3 BLINK_DIV [DIV_W-1:0] blink half-period in clk cycles; 0 disables blinking (phase held visible)
//   4+k DIGIT_k [6:0] digit data, k = 0..N-1
//  Unmapped addresses: writes ignored, reads 0. Unused upper readdata bits are 0.
//  Reset: every register 0; blink counter 0; phase = visible.
//   seg_out = all 1s if ACTIVE_LOW, else all 0s (blank).
//  Blink divider:
//   - cnt increments each clk while BLINK_DIV != 0.
//   - When cnt == BLINK_DIV-1: cnt <= 0, phase toggles.
//   - A write to BLINK_DIV forces cnt <= 0 and phase <= visible the same edge.
//   - BLINK_DIV = 0: cnt held at 0, phase visible.
//   - If BLINK_DIV is lowered below cnt, cnt restarts via that write; no wrap past 2**DIV_W.
//  Segment path: lit_k = ~enable ? 0 : (BLINK[k] & phase==hidden) ? 0 : DECODE[k] ? hex(DIGIT_k[3:0]) : DIGIT_k[6:0].
//   hex table (gfedcba, active-high):
//    0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
//   seg_out[7k+6:7k] <= ACTIVE_LOW ? ~lit_k : lit_k  (registered)
//   Latency: register write at edge n -> seg_out changes at edge n+1; readback valid the cycle after edge n.
//   Phase toggle at edge n -> seg_out changes at edge n+1.
//  Simultaneous write and terminal count: the write's effect wins (counter restart) for BLINK_DIV writes; other writes don't disturb cnt.
//  Reset mid-operation: asynchronously returns everything to reset values regardless of blink state.
// TESTING
//  1 Reset: reset_n=0 -> seg_out all 1s (ACTIVE_LOW=1), all registers read 0.
//  2 CTRL=1, DECODE=0x3F, DIGIT_0..5=0..5 -> digit0 pins 7'h40, digit5 pins ~7'h6D=7'h12; readback DIGIT_3 = 3.
//  3 DECODE=0, DIGIT_2=7'h49 -> digit2 pins 7'h36; CTRL=0 -> all pins 1s next cycle, DIGIT_2 still reads 7'h49.
//  4 BLINK_DIV=4, BLINK=0x01 -> digit0 alternates 4 cycles lit / 4 blank; digit1 steady; BLINK_DIV=0 -> steady lit.
//  5 Write BLINK_DIV=10 on the same edge cnt hits old terminal -> cnt 0, phase visible, next toggle 10 cycles later.
//  6 Write to address 4+NUM_DIGITS and unmapped reads -> no state change, readdata 0; mid-blink reset -> blank pins.

Source files
------------

// File: rtl/seven_seg_multi_ctrl.sv
// Avalon-MM slave driving NUM_DIGITS seven-segment digits, each either raw
// segments or hardware hex-decoded, with per-digit blinking from a divider.
module seven_seg_multi_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int ADDR_W     = 4,
  parameter int ACTIVE_LOW = 1,
  parameter int DIV_W      = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_W-1:0]       address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [7*NUM_DIGITS-1:0] seg_out
);

  typedef enum logic {PHASE_VISIBLE = 1'b0, PHASE_HIDDEN = 1'b1} phase_e;

  localparam logic [7*NUM_DIGITS-1:0] SEG_BLANK = (ACTIVE_LOW != 0) ? '1 : '0;

  logic                  wrEn;
  logic                  blinkDivWr;
  logic                  enable_q;
  logic [NUM_DIGITS-1:0] decode_q;
  logic [NUM_DIGITS-1:0] blink_q;
  logic [DIV_W-1:0]      blinkDiv_q;
  logic [DIV_W-1:0]      blinkCnt_q;
  phase_e                phase_q;
  logic [6:0]            digit_q [NUM_DIGITS];
  logic [6:0]            litDigit [NUM_DIGITS];
  logic [7*NUM_DIGITS-1:0] seg_d;
  logic [7*NUM_DIGITS-1:0] seg_q;

  assign wrEn       = chipselect & ~write_n;
  assign blinkDivWr = wrEn && (address == ADDR_W'(3));

  function automatic logic [6:0] hexSeg(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q   <= 1'b0;
      decode_q   <= '0;
      blink_q    <= '0;
      blinkDiv_q <= '0;
      for (int k = 0; k < NUM_DIGITS; k++) digit_q[k] <= '0;
    end else if (wrEn) begin
      if (address == ADDR_W'(0)) enable_q   <= writedata[0];
      if (address == ADDR_W'(1)) decode_q   <= writedata[NUM_DIGITS-1:0];
      if (address == ADDR_W'(2)) blink_q    <= writedata[NUM_DIGITS-1:0];
      if (address == ADDR_W'(3)) blinkDiv_q <= writedata[DIV_W-1:0];
      for (int k = 0; k < NUM_DIGITS; k++)
        if (address == ADDR_W'(4 + k)) digit_q[k] <= writedata[6:0];
    end
  end

  // A divider write restarts the count and shows the digits, even on the terminal-count edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blinkCnt_q <= '0;
      phase_q    <= PHASE_VISIBLE;
    end else if (blinkDivWr || blinkDiv_q == '0) begin
      blinkCnt_q <= '0;
      phase_q    <= PHASE_VISIBLE;
    end else if (blinkCnt_q == blinkDiv_q - DIV_W'(1)) begin
      blinkCnt_q <= '0;
      phase_q    <= (phase_q == PHASE_VISIBLE) ? PHASE_HIDDEN : PHASE_VISIBLE;
    end else begin
      blinkCnt_q <= blinkCnt_q + DIV_W'(1);
    end
  end

  always_comb begin
    seg_d = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      litDigit[k] = '0;
      if (enable_q && !(blink_q[k] && phase_q == PHASE_HIDDEN))
        litDigit[k] = decode_q[k] ? hexSeg(digit_q[k][3:0]) : digit_q[k];
      seg_d[7*k +: 7] = (ACTIVE_LOW != 0) ? ~litDigit[k] : litDigit[k];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) seg_q <= SEG_BLANK;
    else          seg_q <= seg_d;
  end

  assign seg_out = seg_q;

  always_comb begin
    readdata = '0;
    if (address == ADDR_W'(0)) readdata[0]              = enable_q;
    if (address == ADDR_W'(1)) readdata[NUM_DIGITS-1:0] = decode_q;
    if (address == ADDR_W'(2)) readdata[NUM_DIGITS-1:0] = blink_q;
    if (address == ADDR_W'(3)) readdata[DIV_W-1:0]      = blinkDiv_q;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (address == ADDR_W'(4 + k)) readdata[6:0] = digit_q[k];
  end

endmodule

// File: tb/tb_seven_seg_multi_ctrl.sv
// Directed bench for seven_seg_multi_ctrl: register map, decode, enable,
// blink timing, divider-write collision, unmapped access and async reset.
module tb_seven_seg_multi_ctrl;

  localparam int NUM_DIGITS = 6;
  localparam int ADDR_W     = 4;
  localparam logic [7*NUM_DIGITS-1:0] ALL_OFF = '1;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic [ADDR_W-1:0]       address;
  logic                    chipselect;
  logic                    write_n;
  logic [31:0]             writedata;
  logic [31:0]             readdata;
  logic [7*NUM_DIGITS-1:0] seg_out;

  int errors = 0;
  int checks = 0;

  seven_seg_multi_ctrl #(
    .NUM_DIGITS(NUM_DIGITS), .ADDR_W(ADDR_W), .ACTIVE_LOW(1), .DIV_W(32)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .seg_out(seg_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single-cycle bus write; the register takes the value on the next rising edge.
  task automatic applyStimulus(input int addr, input logic [31:0] data);
    @(negedge clk);
    address = ADDR_W'(addr); writedata = data; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic readReg(input int addr, output logic [31:0] data);
    @(negedge clk);
    address = ADDR_W'(addr); chipselect = 1'b1;
    #1 data = readdata;
    chipselect = 1'b0;
  endtask

  function automatic logic [6:0] pins(input int k);
    return seg_out[7*k +: 7];
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (seg_out !== ALL_OFF) begin
      errors++; $display("[TB] FAIL reset_seg: got %h want %h", seg_out, ALL_OFF);
    end
    for (int a = 0; a < 16; a++) begin
      readReg(a, d);
      checks++;
      if (d !== 32'h0) begin
        errors++; $display("[TB] FAIL reset_read[%0d]: got %h want 0", a, d);
      end
    end
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (seg_out !== ALL_OFF) begin
      errors++; $display("[TB] FAIL post_reset_seg: got %h want %h", seg_out, ALL_OFF);
    end
  endtask

  task automatic test_hex_decode();
    logic [6:0]  expPins [NUM_DIGITS] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12};
    logic [31:0] d;
    applyStimulus(0, 32'h1);
    applyStimulus(1, 32'h3F);
    for (int k = 0; k < NUM_DIGITS; k++) applyStimulus(4 + k, k);
    @(posedge clk); #1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      checks++;
      if (pins(k) !== expPins[k]) begin
        errors++; $display("[TB] FAIL hex_digit%0d: got %h want %h", k, pins(k), expPins[k]);
      end
    end
    readReg(7, d);
    checks++;
    if (d !== 32'h3) begin errors++; $display("[TB] FAIL read_digit3: got %h want 3", d); end
    readReg(1, d);
    checks++;
    if (d !== 32'h3F) begin errors++; $display("[TB] FAIL read_decode: got %h want 3f", d); end
    applyStimulus(8, 32'h7A);
    applyStimulus(9, 32'h0F);
    @(posedge clk); #1;
    checks++;
    if (pins(4) !== 7'h08) begin
      errors++; $display("[TB] FAIL hex_A_low_nibble: got %h want 08", pins(4));
    end
    checks++;
    if (pins(5) !== 7'h0E) begin
      errors++; $display("[TB] FAIL hex_F: got %h want 0e", pins(5));
    end
    applyStimulus(8, 32'h4);
    applyStimulus(9, 32'h5);
  endtask

  task automatic test_raw_and_enable();
    logic [31:0] d;
    applyStimulus(1, 32'h0);
    applyStimulus(6, 32'h49);
    @(posedge clk); #1;
    checks++;
    if (pins(2) !== 7'h36) begin errors++; $display("[TB] FAIL raw_digit2: got %h want 36", pins(2)); end
    checks++;
    if (pins(0) !== 7'h7F) begin errors++; $display("[TB] FAIL raw_digit0: got %h want 7f", pins(0)); end
    checks++;
    if (pins(5) !== 7'h7A) begin errors++; $display("[TB] FAIL raw_digit5: got %h want 7a", pins(5)); end
    applyStimulus(0, 32'h0);
    checks++;
    if (pins(2) !== 7'h36) begin
      errors++; $display("[TB] FAIL disable_latency: got %h want 36", pins(2));
    end
    @(posedge clk); #1;
    checks++;
    if (seg_out !== ALL_OFF) begin
      errors++; $display("[TB] FAIL disable_blank: got %h want %h", seg_out, ALL_OFF);
    end
    readReg(6, d);
    checks++;
    if (d !== 32'h49) begin errors++; $display("[TB] FAIL read_digit2: got %h want 49", d); end
  endtask

  task automatic test_blink();
    logic [6:0] exp0;
    applyStimulus(0, 32'h1);
    applyStimulus(4, 32'h3F);
    applyStimulus(2, 32'h1);
    applyStimulus(3, 32'd4);
    for (int j = 1; j <= 16; j++) begin
      @(posedge clk); #1;
      exp0 = (((j - 1) / 4) % 2 == 0) ? 7'h40 : 7'h7F;
      checks++;
      if (pins(0) !== exp0) begin
        errors++; $display("[TB] FAIL blink_digit0 cycle %0d: got %h want %h", j, pins(0), exp0);
      end
      checks++;
      if (pins(1) !== 7'h7E) begin
        errors++; $display("[TB] FAIL steady_digit1 cycle %0d: got %h want 7e", j, pins(1));
      end
    end
    applyStimulus(3, 32'd0);
    for (int j = 1; j <= 6; j++) begin
      @(posedge clk); #1;
      checks++;
      if (pins(0) !== 7'h40) begin
        errors++; $display("[TB] FAIL div0_visible cycle %0d: got %h want 40", j, pins(0));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp0;
    applyStimulus(3, 32'd4);
    repeat (3) @(posedge clk);
    applyStimulus(3, 32'd10);
    for (int j = 1; j <= 11; j++) begin
      @(posedge clk); #1;
      exp0 = (j <= 10) ? 7'h40 : 7'h7F;
      checks++;
      if (pins(0) !== exp0) begin
        errors++; $display("[TB] FAIL div_collision cycle %0d: got %h want %h", j, pins(0), exp0);
      end
    end
  endtask

  task automatic test_unmapped_and_reset();
    logic [6:0]  expPins [NUM_DIGITS] = '{7'h00, 7'h7E, 7'h36, 7'h7C, 7'h7B, 7'h7A};
    logic [31:0] d;
    applyStimulus(4 + NUM_DIGITS, 32'hFF);
    applyStimulus(0, 32'hFFFF_FFFF);
    applyStimulus(1, 32'hFFFF_FFC0);
    readReg(0, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("[TB] FAIL ctrl_upper_bits: got %h want 1", d); end
    readReg(1, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL decode_upper_bits: got %h want 0", d); end
    for (int a = 4 + NUM_DIGITS; a < 16; a++) begin
      readReg(a, d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("[TB] FAIL unmapped_read[%0d]: got %h want 0", a, d); end
    end
    readReg(9, d);
    checks++;
    if (d !== 32'h5) begin errors++; $display("[TB] FAIL digit5_kept: got %h want 5", d); end
    readReg(3, d);
    checks++;
    if (d !== 32'd10) begin errors++; $display("[TB] FAIL div_kept: got %h want a", d); end
    for (int k = 1; k < NUM_DIGITS; k++) begin
      checks++;
      if (pins(k) !== expPins[k]) begin
        errors++; $display("[TB] FAIL unmapped_pins%0d: got %h want %h", k, pins(k), expPins[k]);
      end
    end
    applyStimulus(3, 32'd3);
    repeat (4) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (seg_out !== ALL_OFF) begin
      errors++; $display("[TB] FAIL async_reset_seg: got %h want %h", seg_out, ALL_OFF);
    end
    readReg(3, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL async_reset_div: got %h want 0", d); end
    readReg(4, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL async_reset_digit0: got %h want 0", d); end
    @(negedge clk) reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (seg_out !== ALL_OFF) begin
      errors++; $display("[TB] FAIL after_reset_seg: got %h want %h", seg_out, ALL_OFF);
    end
  endtask

  initial begin
    test_reset();
    test_hex_decode();
    test_raw_and_enable();
    test_blink();
    test_back_to_back();
    test_unmapped_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
